// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers; define TX_TIMEOUT_EN to abort a handshake the UART never acknowledges
module uart_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 xmit,
  output logic [7:0]           xmit_data,
  input  logic                 xmit_done,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic [15:0]          tx_count,
  output logic                 err_timeout
);
  typedef enum logic [1:0] {IDLE, HOLD, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [2:0] rr_ptr, rr_ptr_n, g, grant_id_n;
  logic [3:0] d, best;
  logic [7:0] g_byte, xmit_data_n;
  logic [NUM_REQ-1:0] req_ready_n;
  logic xmit_n;
  logic [15:0] tx_count_n;
`ifdef TX_TIMEOUT_EN
  logic [15:0] hold_cnt, hold_cnt_n;
  logic err_n;
`endif
  assign busy = state != IDLE;
  // pick the valid requester closest to rr_ptr going upward with wrap
  always_comb begin
    g = '0;
    g_byte = '0;
    best = 4'(NUM_REQ);
    d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (3'(i) >= rr_ptr) ? 4'(3'(i) - rr_ptr) : 4'(i + NUM_REQ) - 4'(rr_ptr);
      if (req_valid[i] && d < best) begin
        best = d;
        g = 3'(i);
        g_byte = req_data[8*i +: 8];
      end
    end
  end
  // next-state and next-output decisions for the grant/hold/wait handshake
  always_comb begin
    state_n = state;
    rr_ptr_n = rr_ptr;
    req_ready_n = '0;
    xmit_n = xmit;
    xmit_data_n = xmit_data;
    grant_id_n = grant_id;
    tx_count_n = tx_count;
`ifdef TX_TIMEOUT_EN
    hold_cnt_n = hold_cnt;
    err_n = 1'b0;
`endif
    if (state == IDLE) begin
      if (xmit_done && |req_valid) begin
        state_n = HOLD;
        xmit_n = 1'b1;
        xmit_data_n = g_byte;
        req_ready_n = NUM_REQ'(1) << g;
        grant_id_n = g;
        rr_ptr_n = (g == 3'(NUM_REQ-1)) ? 3'd0 : g + 3'd1;
`ifdef TX_TIMEOUT_EN
        hold_cnt_n = '0;
`endif
      end
    end else if (state == HOLD) begin
      if (!xmit_done) begin
        xmit_n = 1'b0;
        state_n = WAIT_DONE;
      end
`ifdef TX_TIMEOUT_EN
      else if (hold_cnt == 16'(TIMEOUT_CYC-1)) begin
        xmit_n = 1'b0;
        err_n = 1'b1;
        state_n = IDLE;
      end else hold_cnt_n = hold_cnt + 16'd1;
`endif
    end else if (xmit_done) begin
      tx_count_n = tx_count + 16'd1;
      state_n = IDLE;
    end
  end
  // all state and outputs registered; reset drops xmit without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      req_ready <= '0;
      xmit <= 1'b0;
      xmit_data <= '0;
      grant_id <= '0;
      tx_count <= '0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_ptr_n;
      req_ready <= req_ready_n;
      xmit <= xmit_n;
      xmit_data <= xmit_data_n;
      grant_id <= grant_id_n;
      tx_count <= tx_count_n;
    end
  end
`ifdef TX_TIMEOUT_EN
  // hold-cycle counter and one-cycle timeout pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_n;
      err_timeout <= err_n;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized bench for uart_tx_sched against a transaction-level model
module tb_uart_tx_sched;
  localparam int N = 4;
`ifdef TX_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 65535;
`endif
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_ready, refill = '0;
  logic [8*N-1:0] req_data = '0;
  logic xmit, xmit_done = 1, busy, err_timeout;
  logic [7:0] xmit_data;
  logic [2:0] grant_id;
  logic [15:0] tx_count;
  logic rnd = 0, uart_low = 0, uart_stuck = 0, act = 0;
  int t = 0, errors = 0, checks = 0, ready1_seen = 0, n = 0, base = 0;
  int glog[$];

  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .xmit(xmit), .xmit_data(xmit_data), .xmit_done(xmit_done), .busy(busy),
    .grant_id(grant_id), .tx_count(tx_count), .err_timeout(err_timeout));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (uart_stuck) xmit_done = 1;
    else if (act) begin
      t++;
      if (t == 3) xmit_done = 0;
      else if (t == 23) begin xmit_done = 1; act = 0; end
    end else if (uart_low) xmit_done = 0;
    else if (xmit && xmit_done) begin act = 1; t = 0; end
    else xmit_done = 1;
  end

  logic e_busy, e_xmit, e_err;
  logic [7:0] e_data;
  logic [N-1:0] e_ready;
  logic [2:0] e_gid;
  logic [15:0] e_cnt;
  int ptr, held;
  always @(negedge clk) begin : model
    int g;
    if (rst) begin
      e_busy = 0; e_xmit = 0; e_err = 0; e_data = 0; e_ready = 0; e_gid = 0; e_cnt = 0; ptr = 0; held = 0;
    end else begin
      chk("xmit", xmit, e_xmit);
      chk("xmit_data", xmit_data, e_data);
      chk("req_ready", req_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("grant_id", grant_id, e_gid);
      chk("tx_count", tx_count, e_cnt);
      chk("err_timeout", err_timeout, e_err);
      if ((req_ready & N'(2)) != 0) ready1_seen++;
      e_ready = '0;
      e_err = 0;
      if (!e_busy) begin
        if (xmit_done && req_valid != 0) begin
          g = -1;
          for (int k = 0; k < N; k++)
            if (g < 0 && ((req_valid >> ((ptr + k) % N)) & N'(1)) != 0) g = (ptr + k) % N;
          e_busy = 1; e_xmit = 1; e_data = 8'(req_data >> (8 * g));
          e_ready = N'(1) << g; e_gid = 3'(g); ptr = (g + 1) % N; held = 0;
          glog.push_back(g);
        end
      end else if (e_xmit) begin
        if (!xmit_done) e_xmit = 0;
`ifdef TX_TIMEOUT_EN
        else begin
          held++;
          if (held == TO) begin e_xmit = 0; e_busy = 0; e_err = 1; end
        end
`endif
      end else if (xmit_done) begin
        e_busy = 0;
        e_cnt = e_cnt + 16'd1;
      end
    end
  end

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data = (req_data & ~({{(8*N-8){1'b0}}, 8'hFF} << (8 * i))) | ({{(8*N-8){1'b0}}, b} << (8 * i));
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        req_valid[i] = refill[i];
        set_byte(i, 8'($urandom));
      end else if (rnd) begin
        if (req_valid[i] && $urandom_range(63) == 0) req_valid[i] = 0;
        else if (!req_valid[i] && $urandom_range(7) == 0) begin
          set_byte(i, 8'($urandom));
          req_valid[i] = 1;
        end
      end
    end
    if (rnd) uart_low = $urandom_range(15) == 0;
  endtask

  task automatic wait_grants(input int cnt);
    for (int k = 0; k < 400 && glog.size() < cnt; k++) cyc();
    chk("grant_wait", 32'(glog.size() >= cnt), 1);
  endtask

  task automatic quiesce();
    req_valid = 0; refill = 0; rnd = 0; uart_low = 0;
    for (int k = 0; k < 300 && (busy || act); k++) cyc();
    chk("quiesce", busy, 0);
  endtask

  task automatic do_reset();
    rnd = 0; refill = 0; req_valid = 0; uart_low = 0; uart_stuck = 0;
    rst = 1;
    for (int k = 0; k < 100 && act; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    glog.delete();
    #2 rst = 0;
  endtask

  initial begin
    do_reset();
    cyc();
    chk("rst_xmit", xmit, 0);
    chk("rst_data", xmit_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_cnt", tx_count, 0);
    chk("rst_err", err_timeout, 0);

    set_byte(0, 8'hA5);
    req_valid = 4'b0001;
    wait_grants(1);
    chk("single_ready", req_ready, 4'b0001);
    chk("single_xmit", xmit, 1);
    chk("single_data", xmit_data, 8'hA5);
    cyc();
    chk("single_pulse", req_ready, 0);
    quiesce();
    chk("single_cnt", tx_count, 1);
    chk("single_hold_data", xmit_data, 8'hA5);
    chk("single_gid", grant_id, 0);

    do_reset();
    for (int i = 0; i < N; i++) set_byte(i, 8'(8'h10 + i));
    refill = 4'b1111;
    req_valid = 4'b1111;
    wait_grants(6);
    req_valid = 0; refill = 0;
    quiesce();
    chk("rr_count", tx_count, 6);
    chk("rr_grants", glog.size(), 6);
    chk("rr_g0", glog[0], 0);
    chk("rr_g1", glog[1], 1);
    chk("rr_g2", glog[2], 2);
    chk("rr_g3", glog[3], 3);
    chk("rr_g4", glog[4], 0);
    chk("rr_g5", glog[5], 1);

    base = glog.size();
    set_byte(0, 8'h3C);
    req_valid = 4'b0001;
    wait_grants(base + 1);
    chk("pre_rst_xmit", xmit, 1);
    chk("pre_rst_cnt", tx_count, 6);
    #2 rst = 1;
    #1;
    chk("async_xmit", xmit, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", req_ready, 0);
    chk("async_cnt", tx_count, 0);
    do_reset();

    uart_low = 1;
    cyc(); cyc();
    set_byte(3, 8'hC3);
    req_valid = 4'b1000;
    repeat (10) cyc();
    chk("stall_grants", glog.size(), 0);
    chk("stall_xmit", xmit, 0);
    uart_low = 0;
    wait_grants(1);
    chk("stall_g", glog[0], 3);
    chk("stall_gid", grant_id, 3);
    set_byte(1, 8'h11);
    set_byte(3, 8'h33);
    req_valid = 4'b1010;
    wait_grants(2);
    chk("wrap_g", glog[1], 1);
    wait_grants(3);
    chk("wrap_g2", glog[2], 3);
    quiesce();

    do_reset();
    ready1_seen = 0;
    set_byte(0, 8'h77);
    req_valid = 4'b0001;
    wait_grants(1);
    cyc(); cyc();
    set_byte(1, 8'h99);
    req_valid[1] = 1;
    cyc(); cyc();
    req_valid[1] = 0;
    quiesce();
    repeat (5) cyc();
    chk("withdraw_grants", glog.size(), 1);
    chk("withdraw_ready1", ready1_seen, 0);
    chk("withdraw_cnt", tx_count, 1);

    do_reset();
    rnd = 1;
    repeat (1500) cyc();
    quiesce();
    chk("rand_active", 32'(glog.size() > 20), 1);
    chk("rand_cnt", tx_count, 16'(glog.size()));

`ifdef TX_TIMEOUT_EN
    do_reset();
    uart_stuck = 1;
    set_byte(0, 8'h5A);
    req_valid = 4'b0001;
    wait_grants(1);
    n = 0;
    for (int k = 0; k < 100 && xmit; k++) begin n++; cyc(); end
    chk("to_high_cycles", n, 16);
    chk("to_err", err_timeout, 1);
    chk("to_busy", busy, 0);
    chk("to_cnt", tx_count, 0);
    cyc();
    chk("to_err_pulse", err_timeout, 0);
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
